csr_port_bridge: RTL and testbench

CSR_PORT_BRIDGE -- requirements
Module: csr_port_bridge

---
 rtl/switch_csr_pkg.sv | 24 ++
 rtl/meta_fifo.sv | 78 +++++++
 rtl/csr_port_bridge.sv | 160 ++++++++++++++++
 tb/tb_csr_port_bridge.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/switch_csr_pkg.sv
// Shared definitions for the switch CSR bridge: the CSR word-address map,
// the CTRL mode encoding, the STATUS bit offsets and the CTRL flush bit.
package switch_csr_pkg;

  // CSR word addresses; PORT[p] lives at PORT_BASE + p
  localparam int CTRL_ADDR   = 0;
  localparam int STATUS_ADDR = 1;
  localparam int PORT_BASE   = 2;

  // STATUS layout: non-empty flags from bit 0, overflow flags from bit 16
  localparam int NE_LSB  = 0;
  localparam int OVF_LSB = 16;

  // CTRL bit that requests a flush; it is acted on but never stored
  localparam int FLUSH_BIT = 31;

  typedef enum logic [1:0] {
    MODE_IDLE       = 2'd0,
    MODE_RUN        = 2'd1,
    MODE_EXPERIMENT = 2'd2,
    MODE_RESERVED   = 2'd3
  } mode_t;

endpackage

// File: rtl/meta_fifo.sv
// Synchronous single-clock FIFO holding egress metadata words for one port.
// Ports:
//   clk, reset_n      clock and synchronous active-low reset
//   i_push, i_data    enqueue request and word
//   i_pop             dequeue request (head advances on the edge)
//   i_flush           empty the FIFO on the next edge; overrides push/pop
//   o_head            word at the head (valid while not empty)
//   o_full, o_empty   occupancy flags
//   o_count           number of stored words
module meta_fifo
  import switch_csr_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       i_push,
  input  logic [DATA_W-1:0]          i_data,
  input  logic                       i_pop,
  input  logic                       i_flush,
  output logic [DATA_W-1:0]          o_head,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wrPtr;
  logic [PTR_W-1:0]  r_rdPtr;
  logic [CNT_W-1:0]  r_count;
  logic              w_doPush;
  logic              w_doPop;

  // A push into a full FIFO is only legal when the head leaves in the same
  // cycle; the slot being written is then the one being read out.
  always_comb begin
    w_doPop  = i_pop & ~o_empty;
    w_doPush = i_push & (~o_full | w_doPop);
  end

  // Storage is not reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_doPush) begin
      r_mem[r_wrPtr] <= i_data;
    end
  end

  // Pointer and count bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (!reset_n || i_flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= r_wrPtr + PTR_W'(1);
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      end
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rdPtr];
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/csr_port_bridge.sv
// CSR bridge between a software register bus and NUM_PORTS switch ports.
// Software writes PORT[p] to strobe a word out to port p, reads PORT[p] to
// pop that port's egress metadata FIFO, and uses CTRL/STATUS for mode,
// flush and sticky overflow flags.
// Ports:
//   clk, reset_n                  clock, synchronous active-low reset
//   chipselect, read, write       bus strobes
//   address, writedata, readdata  bus address/data (readdata registered)
//   in_valid, in_data             per-port egress metadata push
//   out_en, out_data              one-cycle one-hot strobe with data
//   out_ack                       per-port pulse when software pops a word
//   experimenting                 high while mode is MODE_EXPERIMENT
module csr_port_bridge
  import switch_csr_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 4
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              chipselect,
  input  logic                              read,
  input  logic                              write,
  input  logic [ADDR_W-1:0]                 address,
  input  logic [DATA_W-1:0]                 writedata,
  output logic [DATA_W-1:0]                 readdata,
  input  logic [NUM_PORTS-1:0]              in_valid,
  input  logic [NUM_PORTS-1:0][DATA_W-1:0]  in_data,
  output logic [NUM_PORTS-1:0]              out_en,
  output logic [DATA_W-1:0]                 out_data,
  output logic [NUM_PORTS-1:0]              out_ack,
  output logic                              experimenting
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  mode_t                              r_mode;
  logic [DATA_W-1:0]                  r_readData;
  logic [DATA_W-1:0]                  r_outData;
  logic [NUM_PORTS-1:0]               r_outEn;
  logic [NUM_PORTS-1:0]               r_outAck;
  logic [NUM_PORTS-1:0]               r_overflow;

  logic                               w_rdAcc;
  logic                               w_wrAcc;
  logic                               w_ctrlSel;
  logic                               w_statusSel;
  logic                               w_flush;
  logic [NUM_PORTS-1:0]               w_portSel;
  logic [NUM_PORTS-1:0]               w_push;
  logic [NUM_PORTS-1:0]               w_pop;
  logic [NUM_PORTS-1:0]               w_ovfEvent;
  logic [NUM_PORTS-1:0]               w_ovfClear;
  logic [NUM_PORTS-1:0]               w_full;
  logic [NUM_PORTS-1:0]               w_empty;
  logic [NUM_PORTS-1:0][DATA_W-1:0]   w_head;
  logic [NUM_PORTS-1:0][CNT_W-1:0]    w_count;
  logic [DATA_W-1:0]                  w_status;
  logic [DATA_W-1:0]                  w_readNext;
  logic                               w_unusedCount;

  // Address decode plus per-port push/pop steering. A full FIFO still
  // accepts a push when software pops it in the same cycle.
  always_comb begin
    w_rdAcc     = chipselect & read;
    w_wrAcc     = chipselect & write;
    w_ctrlSel   = (address == ADDR_W'(CTRL_ADDR));
    w_statusSel = (address == ADDR_W'(STATUS_ADDR));
    w_flush     = w_wrAcc & w_ctrlSel & writedata[FLUSH_BIT];
    w_ovfClear  = (w_wrAcc & w_statusSel) ? writedata[OVF_LSB +: NUM_PORTS] : '0;
    w_portSel   = '0;
    w_pop       = '0;
    w_push      = '0;
    w_ovfEvent  = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_portSel[p]  = (address == ADDR_W'(PORT_BASE + p));
      w_pop[p]      = w_rdAcc & w_portSel[p] & ~w_empty[p];
      w_push[p]     = in_valid[p] & (~w_full[p] | w_pop[p]);
      w_ovfEvent[p] = in_valid[p] & w_full[p] & ~w_pop[p];
    end
  end

  // Read mux; an empty port or unmapped address reads as zero.
  always_comb begin
    w_status                      = '0;
    w_status[NE_LSB +: NUM_PORTS]  = ~w_empty;
    w_status[OVF_LSB +: NUM_PORTS] = r_overflow;
    w_readNext                    = '0;
    if (w_rdAcc) begin
      if (w_ctrlSel) begin
        w_readNext[1:0] = r_mode;
      end else if (w_statusSel) begin
        w_readNext = w_status;
      end else begin
        for (int p = 0; p < NUM_PORTS; p++) begin
          if (w_pop[p]) begin
            w_readNext = w_head[p];
          end
        end
      end
    end
  end

  // Registered bus outputs, strobes, mode and sticky overflow flags.
  // Flush beats everything on the overflow flags; otherwise a new overflow
  // beats a simultaneous write-1-to-clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_mode     <= MODE_IDLE;
      r_readData <= '0;
      r_outEn    <= '0;
      r_outData  <= '0;
      r_outAck   <= '0;
      r_overflow <= '0;
    end else begin
      r_readData <= w_readNext;
      r_outAck   <= w_pop;
      r_outEn    <= w_wrAcc ? w_portSel : '0;
      r_outData  <= (w_wrAcc && (|w_portSel)) ? writedata : '0;
      if (w_wrAcc && w_ctrlSel) begin
        r_mode <= mode_t'(writedata[1:0]);
      end
      if (w_flush) begin
        r_overflow <= '0;
      end else begin
        r_overflow <= (r_overflow & ~w_ovfClear) | w_ovfEvent;
      end
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : gFifo
    meta_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
    ) uFifo (
      .clk     (clk),
      .reset_n (reset_n),
      .i_push  (w_push[g]),
      .i_data  (in_data[g]),
      .i_pop   (w_pop[g]),
      .i_flush (w_flush),
      .o_head  (w_head[g]),
      .o_full  (w_full[g]),
      .o_empty (w_empty[g]),
      .o_count (w_count[g])
    );
  end

  // Occupancy counts are not needed by the bridge itself.
  assign w_unusedCount = ^w_count;

  assign readdata      = r_readData;
  assign out_en        = r_outEn;
  assign out_data      = r_outData;
  assign out_ack       = r_outAck;
  assign experimenting = (r_mode == MODE_EXPERIMENT);

endmodule

// File: tb/tb_csr_port_bridge.sv
// Self-checking bench for csr_port_bridge with a reference model and a
// scoreboard of expected per-cycle outputs.
module tb_csr_port_bridge;

  localparam int NP = 4;
  localparam int DW = 32;
  localparam int FD = 8;
  localparam int AW = 4;

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic                   chipselect;
  logic                   read;
  logic                   write;
  logic [AW-1:0]          address;
  logic [DW-1:0]          writedata;
  logic [DW-1:0]          readdata;
  logic [NP-1:0]          in_valid;
  logic [NP-1:0][DW-1:0]  in_data;
  logic [NP-1:0]          out_en;
  logic [DW-1:0]          out_data;
  logic [NP-1:0]          out_ack;
  logic                   experimenting;

  int nTests = 0;
  int nFail  = 0;

  typedef struct {
    string       tag;
    logic [31:0] rd;
    logic [3:0]  en;
    logic [31:0] od;
    logic [3:0]  ack;
    logic        exper;
  } exp_t;

  exp_t sb[$];

  // Reference model state
  logic [31:0] mMem [NP][FD];
  int          mHead [NP];
  int          mCnt [NP];
  logic [3:0]  mOvf;
  logic [1:0]  mMode;

  always #5 clk = ~clk;

  csr_port_bridge #(
    .NUM_PORTS  (NP),
    .DATA_W     (DW),
    .FIFO_DEPTH (FD),
    .ADDR_W     (AW)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .chipselect    (chipselect),
    .read          (read),
    .write         (write),
    .address       (address),
    .writedata     (writedata),
    .readdata      (readdata),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .out_en        (out_en),
    .out_data      (out_data),
    .out_ack       (out_ack),
    .experimenting (experimenting)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nTests++;
    if (obs !== expv) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, expv);
    end
  endtask

  // Drive one cycle, predict the outputs after the edge, then compare.
  task automatic applyStimulus(input string tag, input logic rstn, input logic cs,
                               input logic rd, input logic wr, input logic [3:0] a,
                               input logic [31:0] wd, input logic [3:0] v,
                               input logic [3:0][31:0] d);
    exp_t        e;
    exp_t        got;
    logic [3:0]  pops;
    logic [3:0]  evt;
    logic [3:0]  clr;
    int          ai;
    ai = int'(a);
    reset_n    = rstn;
    chipselect = cs;
    read       = rd;
    write      = wr;
    address    = a;
    writedata  = wd;
    in_valid   = v;
    in_data    = d;
    e.tag = tag; e.rd = '0; e.en = '0; e.od = '0; e.ack = '0;
    pops = '0; evt = '0; clr = '0;
    if (!rstn) begin
      for (int p = 0; p < NP; p++) begin
        mHead[p] = 0;
        mCnt[p]  = 0;
      end
      mOvf  = '0;
      mMode = 2'd0;
    end else begin
      if (cs && rd) begin
        if (ai == 0) begin
          e.rd = {30'b0, mMode};
        end else if (ai == 1) begin
          for (int p = 0; p < NP; p++) begin
            e.rd[p]      = (mCnt[p] != 0);
            e.rd[16 + p] = mOvf[p];
          end
        end else if (ai >= 2 && ai < 2 + NP) begin
          if (mCnt[ai-2] > 0) begin
            e.rd         = mMem[ai-2][mHead[ai-2]];
            pops[ai-2]   = 1'b1;
          end
        end
      end
      if (cs && wr && ai >= 2 && ai < 2 + NP) begin
        e.en[ai-2] = 1'b1;
        e.od       = wd;
      end
      e.ack = pops;
      if (cs && wr && ai == 1) clr = wd[19:16];
      for (int p = 0; p < NP; p++) begin
        if (pops[p]) begin
          mHead[p] = (mHead[p] + 1) % FD;
          mCnt[p]  = mCnt[p] - 1;
        end
      end
      for (int p = 0; p < NP; p++) begin
        if (v[p]) begin
          if (mCnt[p] < FD) begin
            mMem[p][(mHead[p] + mCnt[p]) % FD] = d[p];
            mCnt[p] = mCnt[p] + 1;
          end else begin
            evt[p] = 1'b1;
          end
        end
      end
      if (cs && wr && ai == 0 && wd[31]) begin
        for (int p = 0; p < NP; p++) begin
          mHead[p] = 0;
          mCnt[p]  = 0;
        end
        mOvf = '0;
      end else begin
        mOvf = (mOvf & ~clr) | evt;
      end
      if (cs && wr && ai == 0) mMode = wd[1:0];
    end
    e.exper = (mMode == 2'd2);
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    checkOutput({got.tag, ".readdata"}, readdata, got.rd);
    checkOutput({got.tag, ".out_en"}, {28'b0, out_en}, {28'b0, got.en});
    checkOutput({got.tag, ".out_data"}, out_data, got.od);
    checkOutput({got.tag, ".out_ack"}, {28'b0, out_ack}, {28'b0, got.ack});
    checkOutput({got.tag, ".experimenting"}, {31'b0, experimenting}, {31'b0, got.exper});
  endtask

  task automatic idleCycle(input string tag);
    applyStimulus(tag, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 4'h0, '0);
  endtask

  task automatic busWrite(input string tag, input logic [3:0] a, input logic [31:0] wd);
    applyStimulus(tag, 1'b1, 1'b1, 1'b0, 1'b1, a, wd, 4'h0, '0);
  endtask

  task automatic busRead(input string tag, input logic [3:0] a);
    applyStimulus(tag, 1'b1, 1'b1, 1'b1, 1'b0, a, 32'h0, 4'h0, '0);
  endtask

  task automatic pushPort(input string tag, input int p, input logic [31:0] word);
    logic [3:0][31:0] d;
    logic [3:0]       v;
    d    = '0;
    v    = '0;
    d[p] = word;
    v[p] = 1'b1;
    applyStimulus(tag, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0, v, d);
  endtask

  initial begin
    logic [3:0][31:0] d;
    logic [31:0]      wd;
    logic [3:0]       a;

    reset_n = 1'b0; chipselect = 1'b0; read = 1'b0; write = 1'b0;
    address = '0; writedata = '0; in_valid = '0; in_data = '0;

    applyStimulus("reset", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 4'h0, '0);
    idleCycle("postReset");

    // Mode register and experimenting flag
    busWrite("ctrlMode2", 4'd0, 32'h2);
    checkOutput("req040.exper1", {31'b0, experimenting}, 32'h1);
    busWrite("ctrlMode1", 4'd0, 32'h1);
    checkOutput("req040.exper0", {31'b0, experimenting}, 32'h0);
    busRead("ctrlRead", 4'd0);
    checkOutput("req040.ctrlRead", readdata, 32'h1);
    idleCycle("afterCtrlRead");

    // Port write strobe
    busWrite("portWrite", 4'd4, 32'hABCD0001);
    checkOutput("req041.en", {28'b0, out_en}, 32'h4);
    checkOutput("req041.data", out_data, 32'hABCD0001);
    idleCycle("portWriteEnd");
    checkOutput("req041.enClear", {28'b0, out_en}, 32'h0);

    // Egress pop order and empty read
    pushPort("push11", 1, 32'h11);
    pushPort("push22", 1, 32'h22);
    busRead("pop1a", 4'd3);
    checkOutput("req042.first", readdata, 32'h11);
    busRead("pop1b", 4'd3);
    checkOutput("req042.second", readdata, 32'h22);
    checkOutput("req042.ack", {28'b0, out_ack}, 32'h2);
    busRead("pop1c", 4'd3);
    checkOutput("req042.emptyAck", {28'b0, out_ack}, 32'h0);

    // Overflow and write-1-to-clear
    for (int i = 0; i < 9; i++) pushPort("fill0", 0, 32'h100 + i);
    busRead("status9", 4'd1);
    checkOutput("req043.status", readdata, 32'h00010001);
    busWrite("statusClr", 4'd1, 32'h00010000);
    busRead("statusAfterClr", 4'd1);
    checkOutput("req043.cleared", readdata, 32'h00000001);

    // Full FIFO with simultaneous push and pop
    for (int i = 0; i < 8; i++) pushPort("fill2", 2, 32'h200 + i);
    d = '0;
    d[2] = 32'h55;
    applyStimulus("fullPushPop", 1'b1, 1'b1, 1'b1, 1'b0, 4'd4, 32'h0, 4'b0100, d);
    checkOutput("req044.head", readdata, 32'h200);
    busRead("statusNoOvf", 4'd1);
    checkOutput("req044.status", readdata, 32'h00000005);
    for (int i = 0; i < 7; i++) busRead("drain2", 4'd4);
    busRead("drain2Last", 4'd4);
    checkOutput("req044.last", readdata, 32'h55);
    busRead("drain2Empty", 4'd4);

    // Read-with-push on empty port, simultaneous read/write, unmapped
    d = '0;
    d[3] = 32'h3333;
    applyStimulus("noBypass", 1'b1, 1'b1, 1'b1, 1'b0, 4'd5, 32'h0, 4'b1000, d);
    checkOutput("noBypass.zero", readdata, 32'h0);
    busRead("afterBypass", 4'd5);
    applyStimulus("rdWrBoth", 1'b1, 1'b1, 1'b1, 1'b1, 4'd1, 32'h0, 4'h0, '0);
    applyStimulus("rdWrPort", 1'b1, 1'b1, 1'b1, 1'b1, 4'd5, 32'h77, 4'h0, '0);
    busWrite("unmappedWr", 4'd9, 32'hFFFF_FFFF);
    busRead("unmappedRd6", 4'd6);
    busRead("unmappedRd15", 4'd15);
    busRead("ctrlAfterUnmapped", 4'd0);

    // Flush with concurrent push, then reset mid-operation
    pushPort("preFlush", 1, 32'hAA);
    d = '0;
    d[1] = 32'hBB;
    applyStimulus("flushPush", 1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 32'h80000000, 4'b0010, d);
    busRead("statusFlushed", 4'd1);
    checkOutput("req045.flushStatus", readdata, 32'h0);
    pushPort("preReset1", 1, 32'hC1);
    pushPort("preReset3", 3, 32'hC3);
    busWrite("preResetMode", 4'd0, 32'h2);
    applyStimulus("midReset", 1'b0, 1'b1, 1'b1, 1'b1, 4'd3, 32'h1234, 4'hF, '0);
    checkOutput("req045.resetEn", {28'b0, out_en}, 32'h0);
    checkOutput("req045.resetExper", {31'b0, experimenting}, 32'h0);
    busRead("statusReset", 4'd1);
    checkOutput("req045.resetStatus", readdata, 32'h0);

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      a  = 4'($urandom_range(0, 7));
      wd = $urandom;
      if (a == 4'd0) wd[31] = ($urandom_range(0, 15) == 0);
      for (int p = 0; p < NP; p++) d[p] = $urandom;
      applyStimulus("rand", ($urandom_range(0, 99) != 0), ($urandom_range(0, 7) != 0),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, wd,
                    4'($urandom_range(0, 15)), d);
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
